// File: rtl/dcache_mem_ctrl.sv
// Memory-side controller for a write-through data cache: FIFO store buffer
// draining to memory, single-word refills on read misses, one req/ack port.
module dcache_mem_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int WB_DEPTH = 4,
  parameter logic [2:0] WORD_MODE = 3'b010
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_req,
  input  logic [ADDR_WIDTH-1:0] miss_addr,
  output logic                  refill_valid,
  output logic [DATA_WIDTH-1:0] refill_data,
  input  logic                  st_valid,
  input  logic [ADDR_WIDTH-1:0] st_addr,
  input  logic [DATA_WIDTH-1:0] st_data,
  input  logic [2:0]            st_addr_mode,
  output logic                  st_ready,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [2:0]            mem_addr_mode,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(WB_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [ADDR_WIDTH-1:0] wb_addr_q [WB_DEPTH];
  logic [ADDR_WIDTH-1:0] wb_addr_d [WB_DEPTH];
  logic [DATA_WIDTH-1:0] wb_data_q [WB_DEPTH];
  logic [DATA_WIDTH-1:0] wb_data_d [WB_DEPTH];
  logic [2:0]            wb_mode_q [WB_DEPTH];
  logic [2:0]            wb_mode_d [WB_DEPTH];
  logic                  mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]            mem_mode_q, mem_mode_d;
  logic [DATA_WIDTH-1:0] refill_data_q, refill_data_d;
  logic                  push, pop, raw_hit;

  assign st_ready      = (count_q != FULL);
  assign refill_valid  = (state_q == S_RESP);
  assign refill_data   = refill_data_q;
  assign stall         = (miss_req && !refill_valid) || (st_valid && !st_ready);
  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_addr_mode = mem_mode_q;

  // A miss may not bypass any buffered store to the same word.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx = '0;
    raw_hit = 1'b0;
    for (int k = 0; k < WB_DEPTH; k++) begin
      idx = rd_ptr_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) &&
          (wb_addr_q[idx][ADDR_WIDTH-1:2] == miss_addr[ADDR_WIDTH-1:2]))
        raw_hit = 1'b1;
    end
  end

  always_comb begin
    push = st_valid && st_ready;
    pop  = (state_q == S_WRITE) && mem_ack;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    wb_mode_d = wb_mode_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push) begin
      wb_addr_d[wr_ptr_q] = st_addr;
      wb_data_d[wr_ptr_q] = st_data;
      wb_mode_d[wr_ptr_q] = st_addr_mode;
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop)
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)
      count_d = count_q + CNT_W'(1);
    else if (pop && !push)
      count_d = count_q - CNT_W'(1);
  end

  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_mode_d    = mem_mode_q;
    refill_data_d = refill_data_q;
    case (state_q)
      S_IDLE: begin
        if (miss_req && !raw_hit) begin
          state_d     = S_READ;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = {miss_addr[ADDR_WIDTH-1:2], 2'b00};
          mem_wdata_d = '0;
          mem_mode_d  = WORD_MODE;
        end else if (count_q != '0) begin
          state_d     = S_WRITE;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = wb_addr_q[rd_ptr_q];
          mem_wdata_d = wb_data_q[rd_ptr_q];
          mem_mode_d  = wb_mode_q[rd_ptr_q];
        end
      end
      S_WRITE: begin
        if (mem_ack) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
        end
      end
      S_READ: begin
        if (mem_ack) begin
          state_d       = S_RESP;
          mem_req_d     = 1'b0;
          refill_data_d = mem_rdata;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_mode_q    <= '0;
      refill_data_q <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_mode_q    <= mem_mode_d;
      refill_data_q <= refill_data_d;
    end
  end

  // Buffer storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    wb_addr_q <= wb_addr_d;
    wb_data_q <= wb_data_d;
    wb_mode_q <= wb_mode_d;
  end

endmodule

// File: tb/tb_dcache_mem_ctrl.sv
// Directed bench for dcache_mem_ctrl with a logging req/ack memory responder.
module tb_dcache_mem_ctrl;

  localparam logic [2:0] MODE_W = 3'b010;
  localparam logic [2:0] MODE_B = 3'b000;

  logic        clk, rst;
  logic        miss_req;
  logic [31:0] miss_addr;
  logic        refill_valid;
  logic [31:0] refill_data;
  logic        st_valid;
  logic [31:0] st_addr, st_data;
  logic [2:0]  st_addr_mode;
  logic        st_ready, stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  mem_addr_mode;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int tests_run = 0;
  int tests_failed = 0;

  logic        ack_en, rand_wait, manual_mode, manual_ack;
  logic [31:0] rdata_val;
  int          wait_cnt;
  logic        lg_we[$];
  logic [31:0] lg_addr[$];
  logic [31:0] lg_data[$];
  logic [2:0]  lg_mode[$];

  dcache_mem_ctrl dut (
    .clk(clk), .rst(rst),
    .miss_req(miss_req), .miss_addr(miss_addr),
    .refill_valid(refill_valid), .refill_data(refill_data),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .st_addr_mode(st_addr_mode), .st_ready(st_ready), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_mode(mem_addr_mode),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: one-cycle ack after an optional wait, logs every transaction.
  always @(negedge clk) begin
    if (!rand_wait && !mem_ack) wait_cnt = 0;
    if (manual_mode) begin
      mem_ack = manual_ack;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (mem_req && ack_en) begin
      if (wait_cnt == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = rdata_val;
        lg_we.push_back(mem_we);
        lg_addr.push_back(mem_addr);
        lg_data.push_back(mem_wdata);
        lg_mode.push_back(mem_addr_mode);
        wait_cnt = rand_wait ? int'($urandom_range(0, 3)) : 0;
      end else begin
        wait_cnt = wait_cnt - 1;
      end
    end
  end

  task automatic clear_log();
    lg_we.delete(); lg_addr.delete(); lg_data.delete(); lg_mode.delete();
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] m);
    int n;
    @(negedge clk);
    st_valid = 1'b1; st_addr = a; st_data = d; st_addr_mode = m;
    n = 0;
    while (!st_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (!st_ready) begin
      tests_failed++;
      $display("FAIL store_accept addr=%h: st_ready stayed 0, required 1", a);
    end
    @(posedge clk); #1;
    st_valid = 1'b0;
  endtask

  task automatic wait_log(input int n, input string name);
    int c;
    c = 0;
    while (lg_addr.size() < n && c < 400) begin
      @(negedge clk);
      c++;
    end
    repeat (4) @(negedge clk);
    tests_run++;
    if (lg_addr.size() != n) begin
      tests_failed++;
      $display("FAIL %s_count: %0d transactions, required %0d", name, lg_addr.size(), n);
    end
  endtask

  task automatic wait_refill(input logic [31:0] exp, input string name);
    int c;
    c = 0;
    while (!refill_valid && c < 200) begin
      @(negedge clk);
      c++;
    end
    tests_run++;
    if (!refill_valid || refill_data !== exp) begin
      tests_failed++;
      $display("FAIL %s_refill: valid=%b data=%h, required valid=1 data=%h",
               name, refill_valid, refill_data, exp);
    end
    @(posedge clk); #1;
    miss_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; miss_req = 1'b1; miss_addr = 32'h0000_0040;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (mem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_req: got %b, required 0", mem_req); end
    tests_run++;
    if (refill_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_refill_valid: got %b, required 0", refill_valid); end
    tests_run++;
    if (st_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_st_ready: got %b, required 1", st_ready); end
    tests_run++;
    if (refill_data !== 32'h0) begin tests_failed++; $display("FAIL reset_refill_data: got %h, required 0", refill_data); end
    tests_run++;
    if (mem_addr !== 32'h0 || mem_we !== 1'b0) begin
      tests_failed++; $display("FAIL reset_mem_addr: got %h we=%b, required 0 we=0", mem_addr, mem_we);
    end
    tests_run++;
    if (stall !== 1'b1) begin tests_failed++; $display("FAIL reset_stall: got %b, required 1", stall); end
    rst = 1'b0; miss_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_clean_miss();
    ack_en = 1'b1; rdata_val = 32'hDEAD_BEEF;
    @(negedge clk);
    miss_req = 1'b1; miss_addr = 32'h0000_1046;
    #1;
    tests_run++;
    if (stall !== 1'b1) begin tests_failed++; $display("FAIL miss_stall_c0: got %b, required 1", stall); end
    @(negedge clk);
    tests_run++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h0000_1044) begin
      tests_failed++;
      $display("FAIL miss_req_c1: req=%b we=%b addr=%h, required req=1 we=0 addr=00001044", mem_req, mem_we, mem_addr);
    end
    tests_run++;
    if (mem_addr_mode !== MODE_W) begin tests_failed++; $display("FAIL miss_mode_c1: got %h, required %h", mem_addr_mode, MODE_W); end
    tests_run++;
    if (stall !== 1'b1) begin tests_failed++; $display("FAIL miss_stall_c1: got %b, required 1", stall); end
    @(negedge clk);
    tests_run++;
    if (refill_valid !== 1'b1 || refill_data !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL miss_refill_c2: valid=%b data=%h, required valid=1 data=deadbeef", refill_valid, refill_data);
    end
    tests_run++;
    if (stall !== 1'b0) begin tests_failed++; $display("FAIL miss_stall_c2: got %b, required 0", stall); end
    @(posedge clk); #1;
    miss_req = 1'b0;
    @(negedge clk);
    tests_run++;
    if (refill_valid !== 1'b0 || mem_req !== 1'b0) begin
      tests_failed++; $display("FAIL miss_after: valid=%b req=%b, required 0 0", refill_valid, mem_req);
    end
  endtask

  task automatic test_buffer_full();
    logic [31:0] exp_a [5];
    exp_a = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110};
    clear_log();
    ack_en = 1'b0;
    for (int i = 0; i < 4; i++) do_store(exp_a[i], exp_a[i] ^ 32'hA5A5_0000, MODE_W);
    @(negedge clk);
    tests_run++;
    if (st_ready !== 1'b0) begin tests_failed++; $display("FAIL full_st_ready: got %b, required 0", st_ready); end
    st_valid = 1'b1; st_addr = exp_a[4]; st_data = exp_a[4] ^ 32'hA5A5_0000; st_addr_mode = MODE_W;
    #1;
    tests_run++;
    if (stall !== 1'b1) begin tests_failed++; $display("FAIL full_stall: got %b, required 1", stall); end
    @(negedge clk);
    tests_run++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h100) begin
      tests_failed++; $display("FAIL full_head_req: req=%b we=%b addr=%h, required 1 1 00000100", mem_req, mem_we, mem_addr);
    end
    ack_en = 1'b1;
    for (int n = 0; n < 100 && !st_ready; n++) @(negedge clk);
    @(posedge clk); #1;
    st_valid = 1'b0;
    wait_log(5, "full");
    for (int i = 0; i < 5 && i < lg_addr.size(); i++) begin
      tests_run++;
      if (lg_we[i] !== 1'b1 || lg_addr[i] !== exp_a[i] || lg_data[i] !== (exp_a[i] ^ 32'hA5A5_0000)) begin
        tests_failed++;
        $display("FAIL full_drain[%0d]: we=%b addr=%h data=%h, required we=1 addr=%h data=%h",
                 i, lg_we[i], lg_addr[i], lg_data[i], exp_a[i], exp_a[i] ^ 32'hA5A5_0000);
      end
    end
  endtask

  task automatic test_read_priority();
    logic        exp_we [3];
    logic [31:0] exp_a [3];
    exp_we = '{1'b0, 1'b1, 1'b1};
    exp_a  = '{32'h300, 32'h200, 32'h204};
    clear_log();
    ack_en = 1'b1; rdata_val = 32'h0BAD_F00D;
    @(negedge clk);
    st_valid = 1'b1; st_addr = 32'h200; st_data = 32'h2222_0000; st_addr_mode = MODE_W;
    @(posedge clk); #1;
    st_addr = 32'h204; st_data = 32'h2222_0004;
    miss_req = 1'b1; miss_addr = 32'h300;
    @(posedge clk); #1;
    st_valid = 1'b0;
    wait_refill(32'h0BAD_F00D, "prio");
    wait_log(3, "prio");
    for (int i = 0; i < 3 && i < lg_addr.size(); i++) begin
      tests_run++;
      if (lg_we[i] !== exp_we[i] || lg_addr[i] !== exp_a[i]) begin
        tests_failed++;
        $display("FAIL prio_order[%0d]: we=%b addr=%h, required we=%b addr=%h", i, lg_we[i], lg_addr[i], exp_we[i], exp_a[i]);
      end
    end
  endtask

  task automatic test_raw_hazard();
    logic        exp_we [3];
    logic [31:0] exp_a [3];
    logic [2:0]  exp_m [3];
    exp_we = '{1'b1, 1'b1, 1'b0};
    exp_a  = '{32'h200, 32'h205, 32'h204};
    exp_m  = '{MODE_W, MODE_B, MODE_W};
    clear_log();
    ack_en = 1'b1; rdata_val = 32'h1234_5678;
    @(negedge clk);
    st_valid = 1'b1; st_addr = 32'h200; st_data = 32'h1111_1111; st_addr_mode = MODE_W;
    @(posedge clk); #1;
    st_addr = 32'h205; st_data = 32'h0000_00AB; st_addr_mode = MODE_B;
    @(posedge clk); #1;
    st_valid = 1'b0;
    miss_req = 1'b1; miss_addr = 32'h204;
    wait_refill(32'h1234_5678, "raw");
    wait_log(3, "raw");
    for (int i = 0; i < 3 && i < lg_addr.size(); i++) begin
      tests_run++;
      if (lg_we[i] !== exp_we[i] || lg_addr[i] !== exp_a[i] || lg_mode[i] !== exp_m[i]) begin
        tests_failed++;
        $display("FAIL raw_order[%0d]: we=%b addr=%h mode=%h, required we=%b addr=%h mode=%h",
                 i, lg_we[i], lg_addr[i], lg_mode[i], exp_we[i], exp_a[i], exp_m[i]);
      end
    end
    tests_run++;
    if (lg_data.size() > 1 && lg_data[1] !== 32'h0000_00AB) begin
      tests_failed++; $display("FAIL raw_byte_data: got %h, required 000000ab", lg_data[1]);
    end
  endtask

  task automatic test_wrap_and_reset();
    logic [31:0] exp_d [10];
    int c;
    logic bad;
    clear_log();
    ack_en = 1'b1; rand_wait = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp_d[i] = $urandom;
      do_store(32'h500 + 32'(4 * i), exp_d[i], MODE_W);
    end
    wait_log(10, "wrap");
    for (int i = 0; i < 10 && i < lg_addr.size(); i++) begin
      tests_run++;
      if (lg_addr[i] !== 32'h500 + 32'(4 * i) || lg_data[i] !== exp_d[i]) begin
        tests_failed++;
        $display("FAIL wrap_order[%0d]: addr=%h data=%h, required addr=%h data=%h",
                 i, lg_addr[i], lg_data[i], 32'h500 + 32'(4 * i), exp_d[i]);
      end
    end
    rand_wait = 1'b0; ack_en = 1'b0;
    repeat (3) @(negedge clk);
    miss_req = 1'b1; miss_addr = 32'h400;
    c = 0;
    while (!mem_req && c < 20) begin
      @(negedge clk);
      c++;
    end
    tests_run++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0) begin
      tests_failed++; $display("FAIL rst_pending_read: req=%b we=%b, required 1 0", mem_req, mem_we);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    manual_ack = 1'b1; manual_mode = 1'b1;
    @(negedge clk);
    tests_run++;
    if (mem_req !== 1'b0) begin tests_failed++; $display("FAIL rst_mem_req_drop: got %b, required 0", mem_req); end
    @(posedge clk); #1;
    rst = 1'b0; miss_req = 1'b0;
    @(posedge clk); #1;
    manual_ack = 1'b0;
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (refill_valid !== 1'b0 || mem_req !== 1'b0) bad = 1'b1;
    end
    tests_run++;
    if (bad) begin tests_failed++; $display("FAIL rst_late_ack: refill_valid/mem_req went high, required both 0"); end
    tests_run++;
    if (st_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_st_ready: got %b, required 1", st_ready); end
    manual_mode = 1'b0;
  endtask

  initial begin
    rst = 1'b0; miss_req = 1'b0; miss_addr = '0;
    st_valid = 1'b0; st_addr = '0; st_data = '0; st_addr_mode = '0;
    mem_ack = 1'b0; mem_rdata = '0; rdata_val = '0; wait_cnt = 0;
    ack_en = 1'b0; rand_wait = 1'b0; manual_mode = 1'b0; manual_ack = 1'b0;
    test_reset();
    test_clean_miss();
    test_buffer_full();
    test_read_priority();
    test_raw_hazard();
    test_wrap_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
